signed_bcd_scanner: RTL
=======================

Name: signed_bcd_scanner

Overview:
Parametrised sequential replacement for the calculator's combinational divide/modulo digit extraction and fixed 8-digit rotator. It accepts a signed binary operand and converts it to BCD iteratively (double-dabble, one bit per cycle). It adds leading-zero blanking, in-field minus sign and overflow indication, then time-multiplexes a selectable window of digits onto the anode drive. It sits between control_unit and DisplayController.

Parameters:
WIDTH, 32, operand width in bits (≥4)
NUM_DIGITS, 8, BCD digits converted (≥2)
AN_DIGITS, 4, physical seven-segment positions (≤NUM_DIGITS)
REFRESH_DIV, 100000, clk cycles each position is lit (1 kHz per digit at 100 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value_in  input  WIDTH  signed operand, two's complement
value_valid  input  1  single-cycle load strobe for value_in
force_neg  input  1  show minus regardless of value (operand entry of "-")
window_upper  input  1  0: show digits 0..AN_DIGITS-1; 1: digits NUM_DIGITS-AN_DIGITS..NUM_DIGITS-1
busy  output  1  conversion in progress
an  output  AN_DIGITS  anode enables, active-low one-hot
digit_val  output  4  BCD value for the lit position
digit_kind  output  2  00 digit, 01 blank, 10 minus, 11 dash (overflow)
dp  output  1  active-low; low on the lit position 0 of the window while window_upper=1
sign_out  output  1  committed sign (value<0 or force_neg)
overflow  output  1  committed |value| ≥ 10^NUM_DIGITS

Behaviour:
- Reset (sync, any state, including mid-conversion): FSM→IDLE, pending cleared, busy=0, overflow=0, sign_out=0, committed BCD=0. Refresh counter=0, scan position=0, an=~1. Display shows "0" at position 0; all other positions are blank.
- FSM IDLE→SHIFT→COMMIT→IDLE.
  - IDLE: value_valid latches mag=|value_in| as unsigned WIDTH bits, so -2^(WIDTH-1) yields 2^(WIDTH-1). It also latches neg=value_in[WIDTH-1] and clears the BCD accumulator; →SHIFT.
  - SHIFT: exactly WIDTH cycles. Each cycle: add 3 to every accumulator nibble ≥5, then shift left one bit, taking mag MSB in. A 1 shifted out of the top nibble sets sticky ovf.
  - COMMIT: one cycle. Copies accumulator, ovf and (neg|force_neg sampled this cycle) into display registers atomically; →IDLE.
- busy=1 from the cycle after acceptance through COMMIT inclusive. Latency from value_valid to updated outputs is WIDTH+2 cycles.
- value_valid while busy: the value is stored in a one-entry pending register (last write wins) and started on the cycle after COMMIT. Intermediate values are dropped. A value_valid in the COMMIT cycle is also held as pending.
- force_neg changes while IDLE update sign_out on the next cycle with no conversion.
- Display formatting, evaluated from committed registers:
  - MSD = highest nonzero digit (0 if value is 0).
  - Positions above MSD are blank.
  - If sign_out and MSD<NUM_DIGITS-1, position MSD+1 shows minus. Otherwise the sign is visible only on sign_out.
  - force_neg with value 0 shows "-0".
  - overflow: every position is kind 11, digit_val=0.
- Scan: the refresh counter counts 0..REFRESH_DIV-1. At wrap, the scan position increments modulo AN_DIGITS, and an/digit outputs update in the same cycle. Lit digit index = position + (window_upper ? NUM_DIGITS-AN_DIGITS : 0). A window_upper change takes effect on the next cycle without resetting the scan.
- All outputs are registered.

Decomposition:
- Shared package calc_pkg:
  - digit_kind codes (KIND_DIGIT, KIND_BLANK, KIND_MINUS, KIND_DASH)
  - FSM state encoding (ST_IDLE, ST_SHIFT, ST_COMMIT)
  - function for clog2 of counter widths
- Sub-module bcd_dabble_core(WIDTH, NUM_DIGITS):
  - contains the add-3/shift datapath, bit counter and ovf sticky
  - ports: start, done, bcd, ovf
- The scanner, formatting and pending logic stay in the top.

Test Plan:
- Params 32/8/4, REFRESH_DIV=4; load 1234 → busy high 33 cycles. Over one scan of 16 cycles, positions 0..3 show digits 4,3,2,1; window_upper=1 shows four blanks; overflow=0, sign_out=0.
- Load -7 → pos0 digit 7, pos1 minus, pos2-7 blank, sign_out=1. Then load 0 with force_neg=1 → pos0 "0", pos1 minus.
- Load 99999999 → all eight digits 9, overflow=0. Load -99999999 → no minus position, sign_out=1. Load 100000000 → all positions dash, overflow=1. Load -2147483648 → overflow=1, sign_out=1.
- Load 5, then pulse 6 and 7 during SHIFT → committed sequence is 5 then 7. Busy remains high continuously across the back-to-back conversion and 6 never appears.
- Assert reset at SHIFT cycle 10 of a 4321 conversion → next cycle busy=0, display "0" at pos0, an=4'b1110, pending discarded.
- WIDTH=8, NUM_DIGITS=3, AN_DIGITS=3: load -128 → digits 8,2,1, no minus slot, sign_out=1. Load 127 → 7,2,1; latency 10 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator display path: digit kinds, the
// conversion FSM states and a width helper for counters.
package calc_pkg;

    localparam logic [1:0] KIND_DIGIT = 2'b00;
    localparam logic [1:0] KIND_BLANK = 2'b01;
    localparam logic [1:0] KIND_MINUS = 2'b10;
    localparam logic [1:0] KIND_DASH  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_COMMIT = 2'b10
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((64'd1 << r) < 64'(n)) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// Iterative binary-to-BCD converter: one add-3/shift step per cycle for
// WIDTH cycles, with a sticky flag for digits lost off the top nibble.
module bcd_dabble_core
    import calc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        mag,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    ovf
);

    localparam int CW = clog2_min1(WIDTH + 1);
    localparam int BW = 4 * NUM_DIGITS;

    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end

    // High during the final shift so the controller can leave SHIFT on time.
    assign done = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sh  <= '0;
            cnt <= '0;
            bcd <= '0;
            ovf <= 1'b0;
        end else if (start) begin
            sh  <= mag;
            cnt <= CW'(WIDTH);
            bcd <= '0;
            ovf <= 1'b0;
        end else if (cnt != '0) begin
            bcd <= {adj[BW-2:0], sh[WIDTH-1]};
            sh  <= sh << 1;
            ovf <= ovf | adj[BW-1];
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/signed_bcd_scanner.sv
// Signed operand to multiplexed seven-segment drive: sequential BCD
// conversion, sign/blank/overflow formatting and a windowed digit scan.
module signed_bcd_scanner
    import calc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int NUM_DIGITS  = 8,
    parameter int AN_DIGITS   = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     value_in,
    input  logic                 value_valid,
    input  logic                 force_neg,
    input  logic                 window_upper,
    output logic                 busy,
    output logic [AN_DIGITS-1:0] an,
    output logic [3:0]           digit_val,
    output logic [1:0]           digit_kind,
    output logic                 dp,
    output logic                 sign_out,
    output logic                 overflow
);

    localparam int RW = clog2_min1(REFRESH_DIV);
    localparam int PW = clog2_min1(AN_DIGITS);
    localparam int BW = 4 * NUM_DIGITS;

    state_t            state;
    logic              pend_vld;
    logic [WIDTH-1:0]  pend_val;
    logic              neg_run, neg_c;
    logic [BW-1:0]     bcd_c, bcd_n;
    logic              ovf_n, sign_n;

    logic              start;
    logic [WIDTH-1:0]  start_val, mag;
    logic              core_done, core_ovf;
    logic [BW-1:0]     core_bcd;

    logic [RW-1:0]     rcnt, rcnt_n;
    logic [PW-1:0]     pos, pos_n;
    logic              wrap;
    logic [AN_DIGITS-1:0] an_n;
    logic [3:0]        val_n;
    logic [1:0]        kind_n;
    logic              dp_n;
    int                idx, msd;

    // A fresh strobe in IDLE beats a pending value; the pending one is dropped.
    always_comb begin
        start     = (state == ST_IDLE) && (value_valid || pend_vld);
        start_val = value_valid ? value_in : pend_val;
        mag       = start_val[WIDTH-1] ? (~start_val + 1'b1) : start_val;
    end

    bcd_dabble_core #(.WIDTH(WIDTH), .NUM_DIGITS(NUM_DIGITS)) u_core (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mag   (mag),
        .done  (core_done),
        .bcd   (core_bcd),
        .ovf   (core_ovf)
    );

    // Values the committed registers hold after this edge; the display is
    // formatted from these so it lands in the same cycle as sign_out/overflow.
    always_comb begin
        bcd_n  = bcd_c;
        ovf_n  = overflow;
        sign_n = sign_out;
        case (state)
            ST_IDLE:   sign_n = neg_c | force_neg;
            ST_COMMIT: begin
                bcd_n  = core_bcd;
                ovf_n  = core_ovf;
                sign_n = neg_run | force_neg;
            end
            default: ;
        endcase
    end

    always_comb begin
        wrap   = (rcnt == RW'(REFRESH_DIV - 1));
        rcnt_n = wrap ? '0 : rcnt + 1'b1;
        pos_n  = pos;
        if (wrap) pos_n = (pos == PW'(AN_DIGITS - 1)) ? '0 : pos + 1'b1;
    end

    always_comb begin
        idx = int'(pos_n) + (window_upper ? (NUM_DIGITS - AN_DIGITS) : 0);
        msd = 0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (bcd_n[4*i +: 4] != 4'd0) msd = i;
        kind_n = KIND_BLANK;
        val_n  = 4'd0;
        if (ovf_n) begin
            kind_n = KIND_DASH;
        end else if (idx <= msd) begin
            kind_n = KIND_DIGIT;
            for (int i = 0; i < NUM_DIGITS; i++)
                if (i == idx) val_n = bcd_n[4*i +: 4];
        end else if (sign_n && idx == msd + 1) begin
            kind_n = KIND_MINUS;
        end
        an_n = ~(AN_DIGITS'(1) << pos_n);
        dp_n = ~(window_upper && pos_n == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            pend_vld   <= 1'b0;
            pend_val   <= '0;
            neg_run    <= 1'b0;
            neg_c      <= 1'b0;
            bcd_c      <= '0;
            overflow   <= 1'b0;
            sign_out   <= 1'b0;
            busy       <= 1'b0;
            rcnt       <= '0;
            pos        <= '0;
            an         <= ~AN_DIGITS'(1);
            digit_val  <= 4'd0;
            digit_kind <= KIND_DIGIT;
            dp         <= 1'b1;
        end else begin
            bcd_c      <= bcd_n;
            overflow   <= ovf_n;
            sign_out   <= sign_n;
            rcnt       <= rcnt_n;
            pos        <= pos_n;
            an         <= an_n;
            digit_val  <= val_n;
            digit_kind <= kind_n;
            dp         <= dp_n;
            case (state)
                ST_IDLE: begin
                    busy <= start;
                    if (start) begin
                        state    <= ST_SHIFT;
                        pend_vld <= 1'b0;
                        neg_run  <= start_val[WIDTH-1];
                    end
                end
                ST_SHIFT: begin
                    if (value_valid) begin
                        pend_vld <= 1'b1;
                        pend_val <= value_in;
                    end
                    if (core_done) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (value_valid) begin
                        pend_vld <= 1'b1;
                        pend_val <= value_in;
                    end
                    neg_c <= neg_run;
                    busy  <= pend_vld | value_valid;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
